// File: rtl/nod_seq_scan.sv
// Sequential nearest-one detector: scans a wide operand one byte per cycle,
// MSB byte first, through a single shared 8-bit NOD and rounds ties upward.

module nod8 (
   input  logic [7:0] byte_i,
   output logic [8:0] nod_o
);
   logic [8:0] ext;

   // ext[i] is the bit just below bit i; a set bit there means round up.
   always_comb begin
      ext   = {byte_i, 1'b0};
      nod_o = '0;
      for (int i = 0; i < 8; i++) begin
         if (byte_i[i]) nod_o = ext[i] ? (9'd2 << i) : (9'd1 << i);
      end
   end
endmodule

module nod_seq_scan #(
   parameter int NBYTES = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [8*NBYTES-1:0] data_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [8*NBYTES:0]   data_o,
   output logic                zero_o,
   output logic                busy_o
);
   localparam int IW = $clog2(NBYTES);
   localparam int OW = 8*NBYTES + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [8*NBYTES-1:0] opnd_q, opnd_d;
   logic [OW-1:0]       data_q, data_d;
   logic                zero_q, zero_d;
   logic                out_valid_q, out_valid_d;

   logic [IW+2:0]       shamt;
   logic [7:0]          byte_sel;
   logic [8*NBYTES:0]   opnd_ext;
   logic                below_bit;
   logic [8:0]          nod_r;
   logic [8:0]          nod_fix;

   assign shamt     = {idx_q, 3'b000};
   assign byte_sel  = 8'(opnd_q >> shamt);
   // opnd_ext[8*idx] is operand bit 8*idx-1, and 0 for the bottom byte.
   assign opnd_ext  = {opnd_q, 1'b0};
   assign below_bit = opnd_ext[shamt];

   nod8 u_nod8 (
      .byte_i (byte_sel),
      .nod_o  (nod_r)
   );

   // A lone LSB can still round up from the top bit of the next byte down.
   assign nod_fix = (byte_sel == 8'h01 && below_bit) ? 9'd2 : nod_r;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      opnd_d      = opnd_q;
      data_d      = data_q;
      zero_d      = zero_q;
      out_valid_d = out_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid_i) begin
               opnd_d  = data_i;
               idx_d   = IW'(NBYTES - 1);
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (byte_sel != 8'h00 || idx_q == '0) begin
               data_d      = OW'(nod_fix) << shamt;
               zero_d      = (byte_sel == 8'h00);
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end
         ST_DONE: begin
            if (out_ready_i) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         opnd_q      <= '0;
         data_q      <= '0;
         zero_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         opnd_q      <= opnd_d;
         data_q      <= data_d;
         zero_q      <= zero_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready_o  = (state_q == ST_IDLE);
   assign busy_o      = (state_q == ST_SCAN);
   assign out_valid_o = out_valid_q;
   assign data_o      = data_q;
   assign zero_o      = zero_q;
endmodule
